memory_access_stage: RTL
========================

Name: memory_access_stage

Overview:
- MEM stage of the 16-bit pipelined CPU.
- Consumes the EX/MEM pipeline register outputs and performs the load/store handshake with data memory.
- Stalls upstream stages while an access is outstanding.
- Produces the registered MEM/WB bundle for the write-back stage.

Parameters:
- DATA_W, 16, datapath width.
- ADDR_W, 12, data-memory address width; address is alu_result_in[ADDR_W-1:0].
- REG_W, 4, destination register index width.
- TIMEOUT, 16, max cycles in WAIT before an access is aborted (>=2).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- valid_in  in  1  EX/MEM slot holds a real instruction
- wbs_in  in  1  instruction writes the register file
- mem_rd_in  in  1  load
- mem_wr_in  in  1  store (mem_rd_in and mem_wr_in both high is treated as store)
- alu_result_in  in  DATA_W  ALU result / effective address
- store_data_in  in  DATA_W  store data
- rd_in  in  REG_W  destination register
- stall_out  out  1  hold EX/MEM and all earlier stages
- mem_req  out  1  memory request, level, held until mem_ready
- mem_we  out  1  write enable for the request
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched store data
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1
- mem_ready  in  1  one-cycle completion pulse
- valid_out  out  1  MEM/WB slot valid
- wbs_out  out  1  write-back enable
- wb_data_out  out  DATA_W  load data or ALU result
- rd_out  out  REG_W  destination register
- err_out  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE.
  - valid_out, wbs_out, mem_req, mem_we, err_out = 0.
  - wb_data_out, rd_out, mem_addr, mem_wdata = 0.
  - Timeout counter = 0.
- FSM states are IDLE and WAIT.
- IDLE, valid_in=1, no memory op:
  - Next edge: valid_out<=1, wbs_out<=wbs_in, wb_data_out<=alu_result_in, rd_out<=rd_in.
  - Latency 1 cycle. stall_out=0.
- IDLE, valid_in=0: valid_out<=0 and wbs_out<=0 (bubble).
- IDLE, valid_in=1, memory op:
  - stall_out=1 combinationally.
  - Next edge: latch mem_addr, mem_wdata, mem_we (=mem_wr_in), wbs, rd, and a load flag.
  - Go to WAIT; valid_out<=0.
- WAIT:
  - mem_req=1. Counter increments each cycle.
  - stall_out = ~mem_ready & ~(counter==TIMEOUT-1).
- WAIT, mem_ready=1:
  - Next edge: valid_out<=1, wbs_out<=latched wbs.
  - wb_data_out<=mem_rdata for a load, latched address-extended ALU result for a store.
  - Return to IDLE, counter<=0.
  - stall drops the same cycle, so the next instruction is presented in IDLE immediately.
  - Minimum memory-op latency: 2 cycles (ready on first WAIT cycle).
- WAIT, counter==TIMEOUT-1 with no mem_ready (abort):
  - Next edge: valid_out<=1, wbs_out<=0, wb_data_out<=0, err_out<=1 (sticky until reset).
  - Return to IDLE.
- mem_ready and timeout in the same cycle: ready wins, no error.
- mem_ready while in IDLE is ignored.
- mem_addr, mem_wdata and mem_we are stable for the whole WAIT.
- Reset asserted mid-WAIT: mem_req drops asynchronously; the outstanding access is abandoned.
- wb_data_out for a store: zero-extended latched ALU result.

Decomposition:
- Shared package cpu_pkg holds:
  - mem_state_t enum {IDLE, WAIT}.
  - DATA_W, REG_W and MEM_TIMEOUT defaults.
- One sub-module: mem_timeout_counter. It provides clear/enable inputs and a terminal-count output, with width $clog2(TIMEOUT).

Test Plan:
- Non-memory op: valid_in=1, wbs=1, alu=16'h1234, rd=3 -> next cycle valid_out=1, wb_data_out=16'h1234, rd_out=3, stall_out never high.
- Load with 3-cycle memory (addr 16'h0040, rdata 16'hBEEF) -> mem_req high 3 cycles, mem_addr=12'h040, stall_out high 3 cycles, then valid_out=1, wb_data_out=16'hBEEF.
- Store with immediate ready (alu=16'h0010, data=16'h00AA) -> mem_we=1, mem_wdata=16'h00AA for 1 WAIT cycle, valid_out=1, wbs_out=0.
- Back-to-back load then ALU op -> ALU result appears in the cycle right after the load result, no extra bubble.
- No mem_ready for 16 cycles -> abort at cycle 16, valid_out=1, wbs_out=0, wb_data_out=0, err_out=1 and stays 1.
- rst=0 during WAIT -> mem_req=0 and valid_out=0 immediately; after release, state IDLE and err_out=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: datapath widths and
// the memory-access stage state encoding.
package cpu_pkg;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 12;
  localparam int REG_W       = 4;
  localparam int MEM_TIMEOUT = 16;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_state_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting on data memory; terminal is high on the last
// permitted wait cycle (count == TIMEOUT-1).
module mem_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // NOTE: clear has priority over enable so a completing access never
  // carries a stale count into the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage: runs the load/store handshake with data memory, stalls the
// front of the pipe while an access is outstanding, and registers MEM/WB.
module memory_access_stage #(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int REG_W   = cpu_pkg::REG_W,
  parameter int TIMEOUT = cpu_pkg::MEM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              wbs_in,
  input  logic              mem_rd_in,
  input  logic              mem_wr_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [REG_W-1:0]  rd_in,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              valid_out,
  output logic              wbs_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic [REG_W-1:0]  rd_out,
  output logic              err_out
);

  import cpu_pkg::*;

  mem_state_t       state;
  logic             lat_wbs;
  logic             lat_load;
  logic [REG_W-1:0] lat_rd;
  logic             mem_op;
  logic             in_wait;
  logic             timed_out;

  assign mem_op  = mem_rd_in | mem_wr_in;
  assign in_wait = (state == WAIT);
  // Derived from state so that reset removes the request asynchronously.
  assign mem_req = in_wait;

  // NOTE: stall is combinational so it drops in the very cycle mem_ready
  // arrives, letting EX/MEM advance on that same edge without a bubble.
  assign stall_out = in_wait ? (~mem_ready & ~timed_out) : (valid_in & mem_op);

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (~in_wait | mem_ready | timed_out),
    .enable   (in_wait),
    .terminal (timed_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      valid_out   <= 1'b0;
      wbs_out     <= 1'b0;
      wb_data_out <= '0;
      rd_out      <= '0;
      err_out     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      lat_wbs     <= 1'b0;
      lat_load    <= 1'b0;
      lat_rd      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in && mem_op) begin
            // Request fields stay frozen for the whole WAIT.
            mem_addr  <= alu_result_in[ADDR_W-1:0];
            mem_wdata <= store_data_in;
            mem_we    <= mem_wr_in;
            lat_wbs   <= wbs_in;
            lat_rd    <= rd_in;
            lat_load  <= ~mem_wr_in;
            valid_out <= 1'b0;
            wbs_out   <= 1'b0;
            state     <= WAIT;
          end else begin
            valid_out <= valid_in;
            wbs_out   <= valid_in & wbs_in;
            if (valid_in) begin
              wb_data_out <= alu_result_in;
              rd_out      <= rd_in;
            end
          end
        end
        WAIT: begin
          if (mem_ready) begin
            valid_out   <= 1'b1;
            wbs_out     <= lat_wbs;
            wb_data_out <= lat_load ? mem_rdata : DATA_W'(mem_addr);
            rd_out      <= lat_rd;
            state       <= IDLE;
          end else if (timed_out) begin
            valid_out   <= 1'b1;
            wbs_out     <= 1'b0;
            wb_data_out <= '0;
            rd_out      <= lat_rd;
            err_out     <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
